// File: rtl/rv32im_regfile_if.sv
// Operand-read / writeback bus between the core and the register file.
// Driven by the core (master), served by the register file (slave).
interface rv32im_regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            we_i;
    logic [AW-1:0]   rs1_addr_i;
    logic [AW-1:0]   rs2_addr_i;
    logic [AW-1:0]   rd_addr_i;
    logic [XLEN-1:0] val_rd_i;
    logic [XLEN-1:0] val_rs1_o;
    logic [XLEN-1:0] val_rs2_o;

    modport master (
        output we_i, rs1_addr_i, rs2_addr_i, rd_addr_i, val_rd_i,
        input  val_rs1_o, val_rs2_o
    );

    modport slave (
        input  we_i, rs1_addr_i, rs2_addr_i, rd_addr_i, val_rd_i,
        output val_rs1_o, val_rs2_o
    );
endinterface

// File: rtl/rv32im_regfile.sv
// RV32IM GPR file, x0 hardwired to zero; reads are combinational with same-cycle write forwarding.
// Latency: 0 cycles read, write lands on the next rising edge; no backpressure (always ready).
module rv32im_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rv32im_regfile_if.slave     rf
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Entry 0 is reset and never written, so it stays a constant zero.
    assign wr_en = rf.we_i && (rf.rd_addr_i != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rf.rd_addr_i] <= rf.val_rd_i;
        end
    end

    assign rs1_hit = wr_en && (rf.rs1_addr_i == rf.rd_addr_i);
    assign rs2_hit = wr_en && (rf.rs2_addr_i == rf.rd_addr_i);

    // Reset also masks forwarding, so nothing is visible while rst_i is high.
    always_comb begin
        rs1_val = '0;
        if (!rst_i && (rf.rs1_addr_i != '0)) begin
            rs1_val = rs1_hit ? rf.val_rd_i : regs[rf.rs1_addr_i];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (!rst_i && (rf.rs2_addr_i != '0)) begin
            rs2_val = rs2_hit ? rf.val_rd_i : regs[rf.rs2_addr_i];
        end
    end

    assign rf.val_rs1_o = rs1_val;
    assign rf.val_rs2_o = rs2_val;

endmodule

// File: tb/tb_rv32im_regfile.sv
// Directed bench for rv32im_regfile: architectural model checked every cycle plus literal expectations.
module tb_rv32im_regfile;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] model [32];

    rv32im_regfile_if #(.XLEN(32), .AW(5)) rf ();

    rv32im_regfile #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rf    (rf)
    );

    always #5 clk_i = ~clk_i;

    // Architectural state: what the registers must hold after each edge.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
        end else if (rf.we_i && rf.rd_addr_i != 5'd0) begin
            model[rf.rd_addr_i] <= rf.val_rd_i;
        end
    end

    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (rst_i || a == 5'd0) return 32'h0;
        if (rf.we_i && rf.rd_addr_i != 5'd0 && rf.rd_addr_i == a) return rf.val_rd_i;
        return model[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        check("model_rs1", rf.val_rs1_o, expect_read(rf.rs1_addr_i));
        check("model_rs2", rf.val_rs2_o, expect_read(rf.rs2_addr_i));
    end

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] val,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk_i);
        #1;
        rf.we_i       = we;
        rf.rd_addr_i  = rd;
        rf.val_rd_i   = val;
        rf.rs1_addr_i = a1;
        rf.rs2_addr_i = a2;
    endtask

    task automatic expect_both(input string name, input logic [31:0] e1, input logic [31:0] e2);
        @(negedge clk_i);
        #1;
        check({name, "_rs1"}, rf.val_rs1_o, e1);
        check({name, "_rs2"}, rf.val_rs2_o, e2);
    endtask

    initial begin
        rst_i         = 1'b0;
        rf.we_i       = 1'b0;
        rf.rd_addr_i  = '0;
        rf.val_rd_i   = '0;
        rf.rs1_addr_i = '0;
        rf.rs2_addr_i = '0;
        #2 rst_i = 1'b1;

        // Reset: outputs are zero even with a pending write
        rf.we_i = 1'b1; rf.rd_addr_i = 5'd4; rf.val_rd_i = 32'h1111; rf.rs1_addr_i = 5'd4;
        expect_both("in_reset", 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
        rst_i = 1'b0;
        expect_both("after_reset", 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        expect_both("reset_x0_x31", 32'h0, 32'h0);

        // Fill x_i = (i+1)*12
        for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 32'((i + 1) * 12), 5'(i), 5'd1);
        for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        expect_both("fill_x1_x2", 32'd24, 32'd36);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
        expect_both("fill_x0_x31", 32'd0, 32'd384);

        // Dual-port reads: same and distinct addresses
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        expect_both("same_addr", 32'd384, 32'd384);
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
        expect_both("distinct_addr", 32'd384, 32'd24);

        // Write x3 while reading others, then forward within the same cycle
        drive(1'b1, 5'd3, 32'd546, 5'd4, 5'd5);
        expect_both("rw_other", 32'd60, 32'd72);
        rf.rs1_addr_i = 5'd3;
        #1;
        check("forward_rs1", rf.val_rs1_o, 32'd546);
        check("forward_rs2_other", rf.val_rs2_o, 32'd72);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        expect_both("x3_stored", 32'd546, 32'd546);

        // Writes to x0 are discarded and never forwarded
        drive(1'b1, 5'd0, 32'd654, 5'd0, 5'd0);
        expect_both("x0_write_fwd", 32'd0, 32'd0);
        rf.rs1_addr_i = 5'd3;
        rf.rs2_addr_i = 5'd3;
        #1;
        check("x0_write_x3_rs1", rf.val_rs1_o, 32'd546);
        check("x0_write_x3_rs2", rf.val_rs2_o, 32'd546);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_both("x0_after", 32'd0, 32'd0);

        // Asynchronous reset mid-operation
        drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0);
        expect_both("x7_fwd", 32'hDEADBEEF, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        expect_both("x7_stored", 32'hDEADBEEF, 32'hDEADBEEF);
        rst_i = 1'b1;
        #1;
        check("async_clear_rs1", rf.val_rs1_o, 32'h0);
        check("async_clear_rs2", rf.val_rs2_o, 32'h0);
        drive(1'b1, 5'd9, 32'd1234, 5'd9, 5'd31);
        expect_both("write_in_reset", 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        rst_i = 1'b0;
        expect_both("dropped_write", 32'h0, 32'h0);
        drive(1'b1, 5'd9, 32'd55, 5'd31, 5'd1);
        expect_both("post_reset_cleared", 32'h0, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
        expect_both("first_write_after_reset", 32'd55, 32'h0);

        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
